// File: rtl/shift_unit_if.sv
// Command/result bundle between the multicycle control unit and shift_unit.
// master = control FSM side, slave = shift datapath side.
interface shift_unit_if #(
  parameter int DATA_W = 32,
  parameter int AMT_W  = 5
) ();
  logic [2:0]        cmd;
  logic              shift_src;
  logic              shift_amt;
  logic [DATA_W-1:0] reg_a;
  logic [DATA_W-1:0] reg_b;
  logic [AMT_W-1:0]  shamt;
  logic [DATA_W-1:0] result;
  logic              busy;
  logic              done;
  logic              cmd_err;

  modport master (
    output cmd, shift_src, shift_amt,
    output reg_a, reg_b, shamt,
    input  result, busy, done, cmd_err
  );

  modport slave (
    input  cmd, shift_src, shift_amt,
    input  reg_a, reg_b, shamt,
    output result, busy, done, cmd_err
  );
endinterface

// File: rtl/shift_unit.sv
// Iterative shift register: load, then one bit per clock until count hits 0.
// SHIFT_UNIT_BARREL_EN: apply the whole shift in one step on acceptance.
module shift_unit #(
  parameter int DATA_W = 32,
  parameter int AMT_W  = 5
) (
  input  logic        clock,
  input  logic        reset,
  shift_unit_if.slave sif
);

  localparam logic [2:0] C_NOP  = 3'b000;
  localparam logic [2:0] C_LOAD = 3'b001;
  localparam logic [2:0] C_SLL  = 3'b010;
  localparam logic [2:0] C_SRL  = 3'b011;
  localparam logic [2:0] C_SRA  = 3'b100;
  localparam logic [2:0] C_ROL  = 3'b101;
  localparam logic [2:0] C_ROR  = 3'b110;
  localparam logic [2:0] C_RSVD = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [AMT_W-1:0]  count_q, count_d;
  logic [2:0]        op_q, op_d;
  logic              loaded_q, loaded_d;
  logic              err_q, err_d;
  logic              is_op;

  function automatic logic [DATA_W-1:0] step1(
    input logic [DATA_W-1:0] v,
    input logic [2:0]        op
  );
    step1 = v;
    case (op)
      C_SLL:   step1 = {v[DATA_W-2:0], 1'b0};
      C_SRL:   step1 = {1'b0, v[DATA_W-1:1]};
      C_SRA:   step1 = {v[DATA_W-1], v[DATA_W-1:1]};
      C_ROL:   step1 = {v[DATA_W-2:0], v[DATA_W-1]};
      C_ROR:   step1 = {v[0], v[DATA_W-1:1]};
      default: step1 = v;
    endcase
  endfunction

`ifdef SHIFT_UNIT_BARREL_EN
  function automatic logic [DATA_W-1:0] barrel(
    input logic [DATA_W-1:0] v,
    input logic [AMT_W-1:0]  n,
    input logic [2:0]        op
  );
    logic [2*DATA_W-1:0] dl;
    logic [2*DATA_W-1:0] dr;
    // Rotates come from shifting a doubled copy of the operand.
    dl = {v, v} << n;
    dr = {v, v} >> n;
    barrel = v;
    case (op)
      C_SLL:   barrel = v << n;
      C_SRL:   barrel = v >> n;
      C_SRA:   barrel = $unsigned($signed(v) >>> n);
      C_ROL:   barrel = dl[2*DATA_W-1:DATA_W];
      C_ROR:   barrel = dr[DATA_W-1:0];
      default: barrel = v;
    endcase
  endfunction
`endif

  assign is_op = (sif.cmd >= C_SLL) && (sif.cmd <= C_ROR);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      count_q  <= '0;
      op_q     <= C_NOP;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      count_q  <= count_d;
      op_q     <= op_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    count_d  = count_q;
    op_d     = op_q;
    loaded_d = loaded_q;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        unique case (1'b1)
          sif.cmd == C_LOAD: begin
            result_d = sif.shift_src ? sif.reg_b : sif.reg_a;
            count_d  = sif.shift_amt ? sif.shamt
                                     : sif.reg_b[AMT_W-1:0];
            loaded_d = 1'b1;
          end
          is_op && loaded_q: begin
            op_d = sif.cmd;
`ifdef SHIFT_UNIT_BARREL_EN
            result_d = barrel(result_q, count_q, sif.cmd);
            state_d  = S_DONE;
`else
            state_d = (count_q == '0) ? S_DONE : S_SHIFT;
`endif
          end
          is_op && !loaded_q: err_d = 1'b1;
          sif.cmd == C_RSVD:  err_d = 1'b1;
          default: ;
        endcase
      end
      S_SHIFT: begin
        result_d = step1(result_q, op_q);
        count_d  = count_q - AMT_W'(1);
        if (count_q == AMT_W'(1)) state_d = S_DONE;
        err_d = (sif.cmd != C_NOP);
      end
      S_DONE: begin
        loaded_d = 1'b0;
        state_d  = S_IDLE;
        err_d    = (sif.cmd != C_NOP);
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign sif.result  = result_q;
  assign sif.busy    = (state_q == S_SHIFT);
  assign sif.done    = (state_q == S_DONE);
  assign sif.cmd_err = err_q;

endmodule

// File: tb/tb_shift_unit.sv
// Self-checking bench for shift_unit with an arithmetic reference model.
module tb_shift_unit;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  shift_unit_if #(.DATA_W(32), .AMT_W(5)) sif ();

  shift_unit #(.DATA_W(32), .AMT_W(5)) dut (
    .clock (clock),
    .reset (reset),
    .sif   (sif)
  );

  always #5 clock = ~clock;

`ifdef SHIFT_UNIT_BARREL_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] v,
                                            input int n,
                                            input logic [2:0] op);
    logic [63:0] w;
    w = {32'd0, v};
    case (op)
      3'b010: return v << n;
      3'b011: return v >> n;
      3'b100: return $unsigned($signed(v) >>> n);
      3'b101: return (v << n) | 32'(w >> (32 - n));
      3'b110: return (v >> n) | 32'((w << (32 - n)) & 64'hFFFF_FFFF);
      default: return v;
    endcase
  endfunction

  task automatic drive_load(input logic [31:0] ra, input logic [31:0] rb,
                            input logic src, input logic asel,
                            input logic [4:0] sh);
    sif.cmd       = 3'b001;
    sif.reg_a     = ra;
    sif.reg_b     = rb;
    sif.shift_src = src;
    sif.shift_amt = asel;
    sif.shamt     = sh;
    tick();
    sif.cmd = 3'b000;
  endtask

  task automatic run_op(input string tag,
                        input logic [31:0] ra, input logic [31:0] rb,
                        input logic src, input logic asel,
                        input logic [4:0] sh, input logic [2:0] op);
    logic [31:0] data, exp;
    int n, k, busy_n, errs;
    data = src ? rb : ra;
    n    = asel ? int'(sh) : int'(rb[4:0]);
    exp  = ref_shift(data, n, op);
    drive_load(ra, rb, src, asel, sh);
    chk({tag, "_load"}, sif.result, data);
    chk({tag, "_ldone"}, {31'd0, sif.done}, 32'd0);
    sif.cmd = op;
    tick();
    sif.cmd = 3'b000;
    k = 0; busy_n = 0; errs = 0;
    while (sif.done !== 1'b1 && k < 40) begin
      if (sif.busy === 1'b1) busy_n++;
      if (sif.cmd_err === 1'b1) errs++;
      tick();
      k++;
    end
    chk({tag, "_done"}, {31'd0, sif.done}, 32'd1);
    chk({tag, "_lat"}, k, BARREL ? 0 : n);
    chk({tag, "_busy"}, busy_n, BARREL ? 0 : n);
    chk({tag, "_err"}, errs, 0);
    chk({tag, "_res"}, sif.result, exp);
    tick();
    chk({tag, "_pulse"}, {31'd0, sif.done}, 32'd0);
    chk({tag, "_hold"}, sif.result, exp);
  endtask

  initial begin
    sif.cmd = 3'b000; sif.shift_src = 1'b0; sif.shift_amt = 1'b0;
    sif.reg_a = '0; sif.reg_b = '0; sif.shamt = '0;
    #12;
    chk("rst_result", sif.result, 32'd0);
    chk("rst_flags", {29'd0, sif.busy, sif.done, sif.cmd_err}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    tick();

    // op with nothing loaded
    sif.cmd = 3'b010;
    tick();
    sif.cmd = 3'b000;
    chk("noload_err", {31'd0, sif.cmd_err}, 32'd1);
    chk("noload_busy", {31'd0, sif.busy}, 32'd0);
    chk("noload_res", sif.result, 32'd0);
    tick();
    chk("noload_pulse", {31'd0, sif.cmd_err}, 32'd0);
    chk("noload_done", {31'd0, sif.done}, 32'd0);

    sif.cmd = 3'b111;
    tick();
    sif.cmd = 3'b000;
    chk("rsvd_err", {31'd0, sif.cmd_err}, 32'd1);
    tick();
    chk("rsvd_pulse", {31'd0, sif.cmd_err}, 32'd0);

    run_op("sll4", 32'h1, 32'h0, 1'b0, 1'b1, 5'd4, 3'b010);
    run_op("sra0", 32'h0, 32'h8000_0000, 1'b1, 1'b0, 5'd9, 3'b100);
    run_op("sra3", 32'h0, 32'h8000_0000, 1'b1, 1'b1, 5'd3, 3'b100);
    run_op("ror1", 32'h8000_0001, 32'h0, 1'b0, 1'b1, 5'd1, 3'b110);
    run_op("rol1", 32'h8000_0001, 32'h0, 1'b0, 1'b1, 5'd1, 3'b101);
    run_op("srl1", 32'h8000_0001, 32'h0, 1'b0, 1'b1, 5'd1, 3'b011);
    run_op("sll31", 32'h1, 32'h0, 1'b0, 1'b1, 5'd31, 3'b010);

    // op after completion needs a fresh load
    sif.cmd = 3'b011;
    tick();
    sif.cmd = 3'b000;
    chk("reuse_err", {31'd0, sif.cmd_err}, 32'd1);
    chk("reuse_res", sif.result, 32'h8000_0000);
    tick();

    // load while busy is rejected and the shift runs on
    drive_load(32'h1, 32'h0, 1'b0, 1'b1, 5'd4);
    sif.cmd = 3'b010;
    tick();
    sif.cmd = 3'b001; sif.reg_a = 32'hDEAD_BEEF;
    tick();
    sif.cmd = 3'b000;
    if (!BARREL) chk("midload_err", {31'd0, sif.cmd_err}, 32'd1);
    for (int i = 0; i < 40 && sif.done !== 1'b1; i++) tick();
    chk("midload_done", {31'd0, sif.done}, 32'd1);
    chk("midload_res", sif.result, 32'h10);
    tick();

    // load in the done cycle is rejected; loaded stays cleared
    drive_load(32'h5, 32'h0, 1'b0, 1'b1, 5'd0);
    sif.cmd = 3'b010;
    tick();
    chk("z_done", {31'd0, sif.done}, 32'd1);
    sif.cmd = 3'b001; sif.reg_a = 32'h7;
    tick();
    chk("z_err", {31'd0, sif.cmd_err}, 32'd1);
    chk("z_res", sif.result, 32'h5);
    sif.cmd = 3'b010;
    tick();
    sif.cmd = 3'b000;
    chk("z_after_err", {31'd0, sif.cmd_err}, 32'd1);
    chk("z_after_busy", {30'd0, sif.busy, sif.done}, 32'd0);
    tick();

    for (int i = 0; i < 30; i++) begin
      logic [31:0] ra, rb;
      logic [2:0] op;
      ra = $urandom;
      rb = $urandom;
      op = 3'($urandom_range(2, 6));
      run_op($sformatf("rnd%0d", i), ra, rb, 1'($urandom),
             1'($urandom), 5'($urandom), op);
    end

    // asynchronous reset in the middle of a long shift
    drive_load(32'h1, 32'h0, 1'b0, 1'b1, 5'd20);
    sif.cmd = 3'b010;
    tick();
    sif.cmd = 3'b000;
    repeat (4) tick();
    #2;
    reset = 1'b0;
    #1;
    chk("arst_res", sif.result, 32'd0);
    chk("arst_flags", {30'd0, sif.busy, sif.done}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    begin
      int dn = 0;
      for (int i = 0; i < 30; i++) begin
        tick();
        if (sif.done === 1'b1 || sif.busy === 1'b1) dn++;
      end
      chk("arst_nodone", dn, 0);
    end
    chk("arst_hold", sif.result, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/shift_unit.md
Name: shift_unit

Overview:
- Datapath shift register that executes the shift commands issued by the multicycle control unit's ShiftControl, ShiftSrc and ShiftAmt outputs.
- Loads an operand and a shift amount, then shifts iteratively, one bit per clock.
- Reports busy/done back so the control FSM can wait on completion instead of assuming a fixed latency.
- Its result feeds the MemToReg mux (input 4).

Parameters:
- DATA_W, 32, operand/result width.
- AMT_W, 5, shift-amount width; must satisfy 2**AMT_W == DATA_W.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd  in  3  000 nop, 001 load, 010 sll, 011 srl, 100 sra, 101 rol, 110 ror, 111 reserved.
- shift_src  in  1  load data select: 0 = reg_a, 1 = reg_b.
- shift_amt  in  1  load amount select: 0 = reg_b[AMT_W-1:0], 1 = shamt.
- reg_a  in  DATA_W  A register output (rs).
- reg_b  in  DATA_W  B register output (rt).
- shamt  in  AMT_W  instruction shamt field.
- result  out  DATA_W  current shift register contents.
- busy  out  1  high while shifting.
- done  out  1  one-cycle pulse when a shift operation completes.
- cmd_err  out  1  one-cycle pulse when a command is rejected.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: result=0, internal count=0, busy=0, done=0, cmd_err=0, state=IDLE, loaded flag=0. Reset asserted mid-shift aborts immediately; no done pulse is produced.
- States: IDLE, SHIFT, DONE.
- IDLE, cmd=001:
  - Latch the selected data into result and the selected amount into count; set loaded=1.
  - Stay in IDLE. No done pulse.
- IDLE, cmd in {010..110} with loaded=1:
  - Latch the op code.
  - count>0: go to SHIFT.
  - count==0: go to DONE with result unchanged.
- IDLE, cmd in {010..110} with loaded=0: pulse cmd_err, stay in IDLE.
- IDLE, cmd=111: pulse cmd_err, stay in IDLE. cmd=000: no action.
- SHIFT:
  - Each edge applies a one-bit shift to result and decrements count. The step depends on the latched op:
    - sll: insert 0 at LSB.
    - srl: insert 0 at MSB.
    - sra: replicate MSB.
    - rol: MSB wraps to LSB.
    - ror: LSB wraps to MSB.
  - On the edge where count reaches 0, go to DONE.
  - busy=1 throughout SHIFT.
- DONE:
  - done=1 for exactly one cycle, busy=0.
  - loaded is cleared; result holds its value until the next load.
  - Next state is IDLE.
- Latency: op accepted at edge T with amount N. Shifts occur at edges T+1..T+N; done is high in the cycle after edge T+N. For N=0, done is high in the cycle after edge T.
- Commands in SHIFT or DONE (any non-000): ignored, cmd_err pulses, the shift is unaffected.
- A load arriving in the same cycle as done is rejected with cmd_err. The control FSM must issue the next command from IDLE.
- count width is AMT_W; the maximum shift is DATA_W-1 (31).
- result changes only on load and on shift edges.

Optional Feature:
- Macro SHIFT_UNIT_BARREL_EN.
- Defined:
  - SHIFT is skipped. The accepted op applies the full N-bit shift in one barrel step on acceptance edge T, and the FSM goes directly to DONE, so done is high in the cycle after T for any N.
  - busy is never asserted.
  - All other rules (cmd_err, loaded, reset) are unchanged.
- Undefined: iterative one-bit-per-cycle behaviour as above.

Test Plan:
- Reset low mid-shift (sll by 20 at cycle 5) -> result=0, busy=0, done=0 immediately; no done pulse after reset is released.
- load reg_a=32'h0000_0001, shamt=4, shift_amt=1, then sll -> busy high for 4 cycles, done pulses once, result=32'h0000_0010.
- load reg_b=32'h8000_0000, shift_src=1, shift_amt=0, reg_b[4:0]=0, then sra -> no busy, done next cycle, result=32'h8000_0000. Repeat with shamt=3, shift_amt=1 -> result=32'hF000_0000 after 3 busy cycles.
- load 32'h8000_0001, amt 1, ror -> result=32'hC000_0000. Same load with rol -> result=32'h0000_0003. Same load with srl -> result=32'h4000_0000.
- sll issued with no prior load -> cmd_err single pulse, result unchanged. cmd=111 -> cmd_err. load during SHIFT -> cmd_err, shift completes with the original result.
- SHIFT_UNIT_BARREL_EN defined: load 32'h1, amt 31, sll -> busy never high, done next cycle, result=32'h8000_0000.
